memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 43 ++++
 rtl/memory_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - host/cpu request ports and register_file port bundle for memory_arbiter
interface memory_arbiter_if;
  logic       host_req;
  logic       host_wr;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;

  logic       cpu_req;
  logic       cpu_wr;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt;
  logic       cpu_rvalid;
  logic [7:0] cpu_rdata;

  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  host_req, host_wr, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus register_file side
  modport master (
    output host_req, host_wr, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-requester round-robin memory arbiter; optional MEM_ARB_HOST_PRIORITY_EN
module memory_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GNT_HOST, GNT_CPU} state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last_cpu;     // 1: cpu was the most recent grantee
  logic       r_host_gnt;
  logic       r_cpu_gnt;
  logic       r_host_rvalid;
  logic       r_cpu_rvalid;
  logic [7:0] r_host_rdata;
  logic [7:0] r_cpu_rdata;

  state_t     w_next;
  logic       w_host_beat;
  logic       w_cpu_beat;
  logic       w_burst_done;
  logic       w_host_preempt;
  logic       w_cpu_preempt;
  logic       w_idle_pick_host;

  assign w_host_beat  = (r_state == GNT_HOST) && bus.host_req;
  assign w_cpu_beat   = (r_state == GNT_CPU) && bus.cpu_req;
  assign w_burst_done = (r_cnt == BURST_LAST);

`ifdef MEM_ARB_HOST_PRIORITY_EN
  assign w_idle_pick_host = 1'b1;
  assign w_host_preempt   = 1'b0;
`else
  assign w_idle_pick_host = r_last_cpu;
  assign w_host_preempt   = w_burst_done && bus.cpu_req;
`endif
  assign w_cpu_preempt = w_burst_done && bus.host_req;

  // Next grant owner: leave on owner release or on an exhausted burst with the other side waiting
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.host_req && bus.cpu_req) w_next = w_idle_pick_host ? GNT_HOST : GNT_CPU;
        else if (bus.host_req)           w_next = GNT_HOST;
        else if (bus.cpu_req)            w_next = GNT_CPU;
      end
      GNT_HOST: begin
        if (!bus.host_req)      w_next = bus.cpu_req ? GNT_CPU : IDLE;
        else if (w_host_preempt) w_next = GNT_CPU;
      end
      GNT_CPU: begin
        if (!bus.cpu_req)       w_next = bus.host_req ? GNT_HOST : IDLE;
        else if (w_cpu_preempt) w_next = GNT_HOST;
      end
      default: w_next = IDLE;
    endcase
  end

  // Grant FSM: state, registered grants, saturating beat counter and round-robin memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_last_cpu <= 1'b1;
      r_host_gnt <= 1'b0;
      r_cpu_gnt  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_host_gnt <= (w_next == GNT_HOST);
      r_cpu_gnt  <= (w_next == GNT_CPU);
      if (w_next != r_state)
        r_cnt <= 4'd0;
      else if ((w_host_beat || w_cpu_beat) && !w_burst_done)
        r_cnt <= r_cnt + 4'd1;
      if (w_next == GNT_HOST) r_last_cpu <= 1'b0;
      else if (w_next == GNT_CPU) r_last_cpu <= 1'b1;
    end
  end

  // Read return: capture register_file data one cycle after a read beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_host_rvalid <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
      r_host_rdata  <= 8'h00;
      r_cpu_rdata   <= 8'h00;
    end else begin
      r_host_rvalid <= w_host_beat && !bus.host_wr;
      r_cpu_rvalid  <= w_cpu_beat && !bus.cpu_wr;
      if (w_host_beat && !bus.host_wr) r_host_rdata <= bus.mem_rdata;
      if (w_cpu_beat && !bus.cpu_wr)   r_cpu_rdata  <= bus.mem_rdata;
    end
  end

  assign bus.mem_wr    = w_host_beat ? bus.host_wr    : (w_cpu_beat ? bus.cpu_wr    : 1'b0);
  assign bus.mem_addr  = w_host_beat ? bus.host_addr  : (w_cpu_beat ? bus.cpu_addr  : 8'h00);
  assign bus.mem_wdata = w_host_beat ? bus.host_wdata : (w_cpu_beat ? bus.cpu_wdata : 8'h00);

  assign bus.host_gnt    = r_host_gnt;
  assign bus.cpu_gnt     = r_cpu_gnt;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.cpu_rvalid  = r_cpu_rvalid;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.cpu_rdata   = r_cpu_rdata;

endmodule
